// File: rtl/sortn_pipe_pkg.sv
// sort_pkg: shared helpers for the bitonic sorting pipeline.
//   clog2       - ceiling log2 of a positive integer
//   stage_count - number of compare-exchange stages for N keys, L*(L+1)/2
//   stage_p     - merge phase of a stage (block size 2^(p+1))
//   stage_q     - exchange distance exponent of a stage (partner = lane ^ 2^q)
//   partner     - lane paired with `lane` in stage `s`
//   cell_desc   - network direction of the cell owning `lane` in stage `s`
//                 (1 = larger key goes to the lower lane); XOR with beat desc
package sort_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << r) < v) r++;
    end
    return r;
  endfunction

  function automatic int stage_count(input int n);
    int l;
    l = clog2(n);
    return l * (l + 1) / 2;
  endfunction

  // Stages are numbered phase by phase: phase p owns p+1 consecutive stages
  // starting at p*(p+1)/2, with the exchange distance halving each stage.
  function automatic int stage_p(input int s);
    int p_r;
    int acc;
    p_r = 0;
    acc = 0;
    for (int p = 0; p < 32; p++) begin
      if (s >= acc) begin
        p_r = p;
        acc = acc + p + 1;
      end
    end
    return p_r;
  endfunction

  function automatic int stage_q(input int s);
    int p;
    p = stage_p(s);
    return p - (s - p * (p + 1) / 2);
  endfunction

  function automatic int partner(input int lane, input int s);
    return lane ^ (1 << stage_q(s));
  endfunction

  // Within phase p, blocks of 2^(p+1) lanes alternate ascending/descending so
  // that the next phase sees bitonic sequences; the final phase is ascending.
  function automatic logic cell_desc(input int lane, input int s);
    return ((lane >> (stage_p(s) + 1)) & 1) != 0;
  endfunction

endpackage

// File: rtl/sortn_pipe_if.sv
// sortn_pipe_if: input and output valid/ready streams of the sorter.
//   in_*  : producer -> sorter beat (valid, desc, tag, N keys), in_ready back
//   out_* : sorter -> consumer beat (valid, desc, tag, N keys), out_ready back
//   slave  modport: the sorter's view
//   master modport: the surrounding logic's view (drives in_*, out_ready)
interface sortn_pipe_if #(
  parameter int N  = 8,
  parameter int W  = 8,
  parameter int TW = 4
);
  logic           in_valid;
  logic           in_ready;
  logic           in_desc;
  logic [TW-1:0]  in_tag;
  logic [N*W-1:0] in_data;
  logic           out_valid;
  logic           out_ready;
  logic           out_desc;
  logic [TW-1:0]  out_tag;
  logic [N*W-1:0] out_data;

  modport slave (
    input  in_valid, in_desc, in_tag, in_data, out_ready,
    output in_ready, out_valid, out_desc, out_tag, out_data
  );

  modport master (
    output in_valid, in_desc, in_tag, in_data, out_ready,
    input  in_ready, out_valid, out_desc, out_tag, out_data
  );
endinterface

// File: rtl/sortn_pipe_cmp_swap.sv
// cmp_swap: combinational unsigned compare-exchange cell.
//   a, b : keys from the lower / upper lane
//   dir  : 0 = smaller key to lo, 1 = larger key to lo
//   lo   : key for the lower lane
//   hi   : key for the upper lane
// Equal keys never swap.
module cmp_swap #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         dir,
  output logic [W-1:0] lo,
  output logic [W-1:0] hi
);
  logic swap;

  assign swap = dir ? (a < b) : (a > b);
  assign lo   = swap ? b : a;
  assign hi   = swap ? a : b;
endmodule

// File: rtl/sortn_pipe.sv
// sortn_pipe: pipelined bitonic sorter, N unsigned W-bit keys per beat.
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : sortn_pipe_if.slave
//         in_valid/in_ready/in_desc/in_tag/in_data  - beat in
//         out_valid/out_ready/out_desc/out_tag/out_data - sorted beat out
// One compare-exchange layer per register stage, S = L*(L+1)/2 stages.
// Every stage advances together when the output is free or being taken, so
// bubbles are kept and a stall freezes the whole pipe. desc and tag ride
// with their beat, allowing mixed-direction beats back to back.
module sortn_pipe
  import sort_pkg::*;
#(
  parameter int N  = 8,
  parameter int W  = 8,
  parameter int TW = 4
) (
  input  logic          clk,
  input  logic          rst,
  sortn_pipe_if.slave   bus
);
  localparam int S = stage_count(N);

  logic [N*W-1:0] stg_data [S];
  logic [TW-1:0]  stg_tag  [S];
  logic [S-1:0]   stg_valid;
  logic [S-1:0]   stg_desc;
  logic           adv;

  assign adv          = bus.out_ready | ~stg_valid[S-1];
  assign bus.in_ready = adv;

  for (genvar s = 0; s < S; s++) begin : g_stage
    localparam int Q = stage_q(s);

    logic [N*W-1:0] src_data;
    logic [TW-1:0]  src_tag;
    logic           src_valid;
    logic           src_desc;
    logic [N*W-1:0] nxt_data;
    logic [N*W-1:0] q_data;
    logic [TW-1:0]  q_tag;
    logic           q_valid;
    logic           q_desc;

    if (s == 0) begin : g_first
      assign src_data  = bus.in_data;
      assign src_tag   = bus.in_tag;
      assign src_valid = bus.in_valid;
      assign src_desc  = bus.in_desc;
    end else begin : g_next
      assign src_data  = stg_data[s-1];
      assign src_tag   = stg_tag[s-1];
      assign src_valid = stg_valid[s-1];
      assign src_desc  = stg_desc[s-1];
    end

    // One cell per lane pair; the lane with bit Q clear owns the cell.
    for (genvar i = 0; i < N; i++) begin : g_lane
      if (((i >> Q) & 1) == 0) begin : g_cell
        localparam int   J  = partner(i, s);
        localparam logic CD = cell_desc(i, s);

        cmp_swap #(.W(W)) u_cmp_swap (
          .a   (src_data[i*W +: W]),
          .b   (src_data[J*W +: W]),
          .dir (CD ^ src_desc),
          .lo  (nxt_data[i*W +: W]),
          .hi  (nxt_data[J*W +: W])
        );
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        q_valid <= 1'b0;
        q_desc  <= 1'b0;
        q_tag   <= '0;
        q_data  <= '0;
      end else if (adv) begin
        q_valid <= src_valid;
        q_desc  <= src_desc;
        q_tag   <= src_tag;
        q_data  <= nxt_data;
      end
    end

    assign stg_data[s]  = q_data;
    assign stg_tag[s]   = q_tag;
    assign stg_valid[s] = q_valid;
    assign stg_desc[s]  = q_desc;
  end

  assign bus.out_valid = stg_valid[S-1];
  assign bus.out_desc  = stg_desc[S-1];
  assign bus.out_tag   = stg_tag[S-1];
  assign bus.out_data  = stg_data[S-1];
endmodule

// File: doc/sortn_pipe.md
Name: sortn_pipe

Overview:
- Parametrised pipelined sorting network; the next generation of the 4-input fixed sorter.
- Sorts N unsigned W-bit keys per beat as a bitonic network, one compare-exchange layer per register stage.
- Adds per-beat ascending/descending mode, valid/ready flow control with back-pressure, and a pass-through tag.
- Sits between a sample-capture front end and downstream consumers (median/rank logic).

Parameters:
- N, 8, number of keys per beat; power of two, 2..32.
- W, 8, key width in bits.
- TW, 4, width of the user tag carried alongside each beat.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  input beat present.
- in_ready  out  1  block accepts the beat this cycle.
- in_desc  in  1  1 = sort descending, 0 = ascending; sampled with the beat.
- in_tag  in  TW  sideband carried unchanged with the beat.
- in_data  in  N*W  keys; lane i at bits [i*W +: W].
- out_valid  out  1  sorted beat present.
- out_ready  in  1  consumer accepts the beat.
- out_desc  out  1  mode of the beat on out_data.
- out_tag  out  TW  tag of the beat on out_data.
- out_data  out  N*W  sorted keys; lane 0 is smallest (asc) or largest (desc).

Behaviour:
- Stage count S = L*(L+1)/2, with L = log2(N). N=8 gives S=6; N=4 gives S=3.
- Each stage has one register bank: valid bit, desc bit, tag, N keys.
- Global advance enable: adv = out_ready OR NOT out_valid.
  - adv = 1: every stage loads from its predecessor.
  - adv = 0: every stage holds.
- in_ready = adv, driven combinationally from out_ready and the last-stage valid.
- A beat is accepted when in_valid AND in_ready. With in_valid = 0 during adv, stage 0 loads valid = 0, so bubbles propagate and are not compressed.
- Latency is exactly S cycles from acceptance to out_valid when no stall occurs. Throughput is one beat per cycle.
- Compare-exchange rule:
  - Unsigned compare.
  - Each cell swaps when the direction given by the network stage (XOR beat desc) requires it.
  - Equal keys: no swap. Sort stability is not guaranteed.
- desc and tag travel with their beat, so mixed-mode beats may be interleaved back-to-back.
- Stall: while out_valid = 1 and out_ready = 0, out_data, out_desc, out_tag and out_valid stay stable and in_ready = 0 (AXI-style hold).
- Registered outputs: out_valid, out_desc, out_tag and out_data come directly from the last stage's registers.
- Reset (rst = 0, asynchronous):
  - All stage valid bits go to 0; out_valid = 0, out_data = 0, out_tag = 0, out_desc = 0.
  - Data registers are also cleared for determinism.
- Reset mid-flight: all in-flight beats are discarded and nothing is emitted. The first accepted beat after release appears S cycles later.
- Release: in_ready = 1 in the first cycle after rst deasserts, because out_valid = 0.
- Width rules: no arithmetic growth; keys keep W bits. Extremes 0 and 2^W-1 must sort correctly.

Decomposition:
- Shared package sort_pkg:
  - function clog2;
  - function stage count S(N);
  - function giving the partner index and direction for a lane/stage, so the bench's reference model reuses it.
- Sub-module cmp_swap (W, combinational):
  - inputs a, b, dir;
  - outputs lo/hi in the requested order.
- The top module generates the stage register banks and instantiates cmp_swap N/2 times per stage.

Test Plan (N=8, W=8, TW=4):
- Single beat, asc: in_data lanes 0..7 = 38,94,61,50,24,15,82,65, tag 3 -> 6 cycles later out_valid = 1, lanes = 15,24,38,50,61,65,82,94, out_tag = 3.
- Back-to-back interleaved mode:
  - beat A asc = 89,20,63,51,72,24,36,77, then beat B desc = 50,69,13,30,23,60,30,11;
  - -> consecutive outputs 20,24,36,51,63,72,77,89 then 69,60,50,30,30,23,13,11, with out_desc = 0 then 1.
- Back-pressure:
  - stream 4 beats with out_ready = 0 from cycle 7 for 5 cycles;
  - -> out_data and out_tag stay frozen, in_ready = 0 throughout, no beat lost or duplicated, order preserved after release.
- Extremes/duplicates: 255,0,255,0,128,128,1,254 asc -> 0,0,1,128,128,254,255,255.
- Bubbles: beats accepted at cycles 0, 2 and 5 -> out_valid pulses exactly at cycles 6, 8 and 11.
- Reset mid-flight:
  - assert rst = 0 asynchronously with 3 beats in flight;
  - -> out_valid drops immediately and no stale beat is emitted after release;
  - a new beat accepted in the first post-release cycle emerges 6 cycles later.
- Randomised soak: 1000 random beats with random desc and random out_ready, checked against the sort_pkg model.
